// File: rtl/stage_cascade_sequencer.sv
// Walks the Haar cascade for one window: streams each stage's parameter and threshold
// words from the stage database, then collects the stage verdict. Optional macro: STAGE_EARLY_EXIT_EN.
module stage_cascade_sequencer #(
    parameter int unsigned NUM_STAGES               = 2,
    parameter int unsigned NUM_CLASSIFIERS_STAGE    = 10,
    parameter int unsigned NUM_PARAM_PER_CLASSIFIER = 19,
    parameter int unsigned NUM_STAGE_THRESHOLD      = 3,
    parameter int unsigned ADDR_WIDTH               = 10,
    parameter int unsigned DATA_WIDTH_12            = 12
) (
    input  logic                     clk_fpga,
    input  logic                     reset_fpga,
    input  logic                     i_start,
    output logic                     o_busy,
    output logic                     o_db_rden,
    output logic [ADDR_WIDTH-1:0]    o_db_addr,
    input  logic [DATA_WIDTH_12-1:0] i_db_data,
    output logic                     o_param_valid,
    input  logic                     i_param_ready,
    output logic [DATA_WIDTH_12-1:0] o_param_data,
    output logic                     o_param_is_thresh,
    output logic [ADDR_WIDTH-1:0]    o_stage_index,
    output logic [ADDR_WIDTH-1:0]    o_classifier_index,
    output logic [ADDR_WIDTH-1:0]    o_param_index,
    output logic                     o_last_word,
    input  logic                     i_stage_result_valid,
    input  logic                     i_stage_pass,
    output logic                     o_done,
    output logic                     o_face_detected
);

    localparam int unsigned WORDS_PER_STAGE =
        NUM_CLASSIFIERS_STAGE * NUM_PARAM_PER_CLASSIFIER + NUM_STAGE_THRESHOLD;

    localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] WPS        = ADDR_WIDTH'(WORDS_PER_STAGE);
    localparam logic [ADDR_WIDTH-1:0] LAST_STAGE = ADDR_WIDTH'(NUM_STAGES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_CLS   = ADDR_WIDTH'(NUM_CLASSIFIERS_STAGE - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_PRM   = ADDR_WIDTH'(NUM_PARAM_PER_CLASSIFIER - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_THR   = ADDR_WIDTH'(NUM_STAGE_THRESHOLD - 1);
    localparam logic                  FIRST_LAST = (WORDS_PER_STAGE == 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EMIT,
        WAIT_RESULT,
        DONE
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   offset;
    logic [ADDR_WIDTH-1:0]   stage_base;
    logic                    acc;

    logic [ADDR_WIDTH-1:0]   nxt_cls;
    logic [ADDR_WIDTH-1:0]   nxt_prm;
    logic                    nxt_thresh;
    logic                    nxt_last;
    logic                    finish_c;

    // Position of the word following the current one, and whether a verdict ends the window
    always_comb begin
        nxt_cls    = o_classifier_index;
        nxt_prm    = o_param_index + ONE;
        nxt_thresh = o_param_is_thresh;
        if (!o_param_is_thresh && (o_param_index == LAST_PRM)) begin
            nxt_prm = '0;
            if (o_classifier_index == LAST_CLS) begin
                nxt_thresh = 1'b1;
            end else begin
                nxt_cls = o_classifier_index + ONE;
            end
        end
        nxt_last = nxt_thresh && (nxt_prm == LAST_THR);
`ifdef STAGE_EARLY_EXIT_EN
        finish_c = (o_stage_index == LAST_STAGE) || !i_stage_pass;
`else
        finish_c = (o_stage_index == LAST_STAGE);
`endif
    end

    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            state              <= IDLE;
            offset             <= '0;
            stage_base         <= '0;
            acc                <= 1'b0;
            o_busy             <= 1'b0;
            o_db_rden          <= 1'b0;
            o_db_addr          <= '0;
            o_param_valid      <= 1'b0;
            o_param_data       <= '0;
            o_param_is_thresh  <= 1'b0;
            o_stage_index      <= '0;
            o_classifier_index <= '0;
            o_param_index      <= '0;
            o_last_word        <= 1'b0;
            o_done             <= 1'b0;
            o_face_detected    <= 1'b0;
        end else begin
            o_done    <= 1'b0;
            o_db_rden <= 1'b0;
            case (state)
                IDLE: begin
                    offset             <= '0;
                    stage_base         <= '0;
                    acc                <= 1'b1;
                    o_stage_index      <= '0;
                    o_classifier_index <= '0;
                    o_param_index      <= '0;
                    o_param_is_thresh  <= 1'b0;
                    o_last_word        <= 1'b0;
                    if (i_start) begin
                        state           <= FETCH;
                        o_busy          <= 1'b1;
                        o_face_detected <= 1'b0;
                        o_db_rden       <= 1'b1;
                        o_db_addr       <= '0;
                        o_last_word     <= FIRST_LAST;
                    end
                end
                FETCH: begin
                    o_param_data  <= i_db_data;
                    o_param_valid <= 1'b1;
                    state         <= EMIT;
                end
                EMIT: begin
                    if (i_param_ready) begin
                        o_param_valid <= 1'b0;
                        if (o_last_word) begin
                            state <= WAIT_RESULT;
                        end else begin
                            o_classifier_index <= nxt_cls;
                            o_param_index      <= nxt_prm;
                            o_param_is_thresh  <= nxt_thresh;
                            o_last_word        <= nxt_last;
                            offset             <= offset + ONE;
                            o_db_addr          <= stage_base + offset + ONE;
                            o_db_rden          <= 1'b1;
                            state              <= FETCH;
                        end
                    end
                end
                WAIT_RESULT: begin
                    if (i_stage_result_valid) begin
                        acc <= acc & i_stage_pass;
                        if (finish_c) begin
                            o_done          <= 1'b1;
                            o_face_detected <= acc & i_stage_pass;
                            state           <= DONE;
                        end else begin
                            o_stage_index      <= o_stage_index + ONE;
                            stage_base         <= stage_base + WPS;
                            o_classifier_index <= '0;
                            o_param_index      <= '0;
                            o_param_is_thresh  <= 1'b0;
                            o_last_word        <= FIRST_LAST;
                            offset             <= '0;
                            o_db_addr          <= stage_base + WPS;
                            o_db_rden          <= 1'b1;
                            state              <= FETCH;
                        end
                    end
                end
                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_cascade_sequencer.sv
// Directed bench for stage_cascade_sequencer with a small cascade (2 stages x 2 classifiers x 3 params + 1 threshold).
module tb_stage_cascade_sequencer;

    localparam int unsigned NS  = 2;
    localparam int unsigned NC  = 2;
    localparam int unsigned NP  = 3;
    localparam int unsigned NT  = 1;
    localparam int unsigned AW  = 10;
    localparam int unsigned DW  = 12;
`ifdef STAGE_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clk_fpga = 1'b0;
    logic          reset_fpga;
    logic          i_start;
    logic          o_busy;
    logic          o_db_rden;
    logic [AW-1:0] o_db_addr;
    logic [DW-1:0] i_db_data;
    logic          o_param_valid;
    logic          i_param_ready;
    logic [DW-1:0] o_param_data;
    logic          o_param_is_thresh;
    logic [AW-1:0] o_stage_index;
    logic [AW-1:0] o_classifier_index;
    logic [AW-1:0] o_param_index;
    logic          o_last_word;
    logic          i_stage_result_valid;
    logic          i_stage_pass;
    logic          o_done;
    logic          o_face_detected;

    always #5 clk_fpga = ~clk_fpga;

    stage_cascade_sequencer #(
        .NUM_STAGES(NS),
        .NUM_CLASSIFIERS_STAGE(NC),
        .NUM_PARAM_PER_CLASSIFIER(NP),
        .NUM_STAGE_THRESHOLD(NT),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH_12(DW)
    ) dut (
        .clk_fpga(clk_fpga),
        .reset_fpga(reset_fpga),
        .i_start(i_start),
        .o_busy(o_busy),
        .o_db_rden(o_db_rden),
        .o_db_addr(o_db_addr),
        .i_db_data(i_db_data),
        .o_param_valid(o_param_valid),
        .i_param_ready(i_param_ready),
        .o_param_data(o_param_data),
        .o_param_is_thresh(o_param_is_thresh),
        .o_stage_index(o_stage_index),
        .o_classifier_index(o_classifier_index),
        .o_param_index(o_param_index),
        .o_last_word(o_last_word),
        .i_stage_result_valid(i_stage_result_valid),
        .i_stage_pass(i_stage_pass),
        .o_done(o_done),
        .o_face_detected(o_face_detected)
    );

    // Database model: word[a] = a + 100, presented while the read strobe is up
    assign i_db_data = o_db_rden ? DW'(int'(o_db_addr) + 100) : '0;

    typedef struct {
        int addr;
        int data;
        int stage;
        int cls;
        int prm;
        int thr;
        int last;
    } vec_t;

    typedef struct {
        int data;
        int stage;
        int cls;
        int prm;
        int thr;
        int last;
    } word_t;

    vec_t  vecs[14];
    int    addr_log[$];
    word_t word_log[$];
    int    done_cnt    = 0;
    int    face_at_done = 0;
    int    last_hs_cnt = 0;
    int    checks      = 0;
    int    failures    = 0;

    // Observer: records issued addresses, accepted words and done pulses
    always @(negedge clk_fpga) begin
        word_t w;
        if (reset_fpga && o_db_rden) addr_log.push_back(int'(o_db_addr));
        if (reset_fpga && o_param_valid && i_param_ready) begin
            w.data  = int'(o_param_data);
            w.stage = int'(o_stage_index);
            w.cls   = int'(o_classifier_index);
            w.prm   = int'(o_param_index);
            w.thr   = int'(o_param_is_thresh);
            w.last  = int'(o_last_word);
            word_log.push_back(w);
            if (o_last_word) last_hs_cnt++;
        end
        if (reset_fpga && o_done) begin
            done_cnt++;
            face_at_done = int'(o_face_detected);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_fpga);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  int'(o_busy), 0);
        chk({tag, "_rden"},  int'(o_db_rden), 0);
        chk({tag, "_addr"},  int'(o_db_addr), 0);
        chk({tag, "_valid"}, int'(o_param_valid), 0);
        chk({tag, "_data"},  int'(o_param_data), 0);
        chk({tag, "_thr"},   int'(o_param_is_thresh), 0);
        chk({tag, "_stage"}, int'(o_stage_index), 0);
        chk({tag, "_cls"},   int'(o_classifier_index), 0);
        chk({tag, "_prm"},   int'(o_param_index), 0);
        chk({tag, "_last"},  int'(o_last_word), 0);
        chk({tag, "_done"},  int'(o_done), 0);
        chk({tag, "_face"},  int'(o_face_detected), 0);
    endtask

    task automatic run_window(input int pass0, input int pass1, input int stall_addr,
                              input int stall_len, input int spurious, input int abort_addr,
                              output int ba, output int bw, output int bd);
        int  seen;
        int  results;
        int  stall_cnt;
        bit  finished;
        bit  aborted;
        bit  gave;
        bit  stalled;
        bit  exp_done;
        ba        = addr_log.size();
        bw        = word_log.size();
        bd        = done_cnt;
        seen      = last_hs_cnt;
        results   = 0;
        stall_cnt = 0;
        finished  = 1'b0;
        aborted   = 1'b0;
        i_param_ready        = 1'b1;
        i_stage_result_valid = 1'b0;
        i_stage_pass         = 1'b0;
        i_start              = 1'b1;
        tick();
        i_start = 1'b0;
        chk("start_rden", int'(o_db_rden), 1);
        chk("start_addr", int'(o_db_addr), 0);
        chk("start_busy", int'(o_busy), 1);
        tick();
        chk("first_valid", int'(o_param_valid), 1);
        chk("first_data", int'(o_param_data), 100);
        for (int cyc = 0; cyc < 400 && !finished && !aborted; cyc++) begin
            i_param_ready        = 1'b1;
            i_stage_result_valid = 1'b0;
            i_stage_pass         = 1'b0;
            i_start              = 1'b0;
            gave                 = 1'b0;
            stalled              = 1'b0;
            if (last_hs_cnt != seen) begin
                seen++;
                i_stage_result_valid = 1'b1;
                i_stage_pass         = (results == 0) ? pass0[0] : pass1[0];
                gave                 = 1'b1;
            end else if (o_param_valid && addr_log[$] == stall_addr && stall_cnt < stall_len) begin
                i_param_ready = 1'b0;
                stall_cnt++;
                stalled = 1'b1;
            end
            if (spurious != 0 && o_param_valid && !gave) begin
                i_start = (cyc % 3 == 0);
                if (cyc % 4 == 1) begin
                    i_stage_result_valid = 1'b1;
                    i_stage_pass         = 1'b0;
                end
            end
            if (o_param_valid && addr_log[$] == abort_addr) begin
                reset_fpga = 1'b0;
                #1;
                chk_all_zero("abort");
                aborted = 1'b1;
            end else begin
                tick();
                if (gave) begin
                    exp_done = (results == NS - 1) || (EARLY && !i_stage_pass);
                    chk(exp_done ? "result_to_done" : "result_to_rden",
                        exp_done ? int'(o_done) : int'(o_db_rden), 1);
                    results++;
                end
                if (stalled) begin
                    chk("stall_data",  int'(o_param_data), 104);
                    chk("stall_stage", int'(o_stage_index), 0);
                    chk("stall_cls",   int'(o_classifier_index), 1);
                    chk("stall_prm",   int'(o_param_index), 1);
                    chk("stall_rden",  int'(o_db_rden), 0);
                end
                if (o_done) finished = 1'b1;
            end
        end
        i_start              = 1'b0;
        i_stage_result_valid = 1'b0;
        i_stage_pass         = 1'b0;
        if (!finished && !aborted) chk("done_timeout", 0, 1);
        if (finished) begin
            tick();
            chk("busy_after_done", int'(o_busy), 0);
        end
    endtask

    task automatic compare_run(input int ba, input int bw, input int bd, input int n_exp,
                               input int face_exp);
        chk("addr_count", addr_log.size() - ba, n_exp);
        chk("word_count", word_log.size() - bw, n_exp);
        for (int i = 0; i < n_exp; i++) begin
            if (ba + i < addr_log.size())
                chk($sformatf("addr[%0d]", i), addr_log[ba + i], vecs[i].addr);
            if (bw + i < word_log.size()) begin
                chk($sformatf("data[%0d]", i),  word_log[bw + i].data,  vecs[i].data);
                chk($sformatf("stage[%0d]", i), word_log[bw + i].stage, vecs[i].stage);
                chk($sformatf("cls[%0d]", i),   word_log[bw + i].cls,   vecs[i].cls);
                chk($sformatf("prm[%0d]", i),   word_log[bw + i].prm,   vecs[i].prm);
                chk($sformatf("thr[%0d]", i),   word_log[bw + i].thr,   vecs[i].thr);
                chk($sformatf("last[%0d]", i),  word_log[bw + i].last,  vecs[i].last);
            end
        end
        chk("done_count", done_cnt - bd, 1);
        chk("face_at_done", face_at_done, face_exp);
        chk("face_hold", int'(o_face_detected), face_exp);
    endtask

    initial begin
        int ba;
        int bw;
        int bd;
        //            addr data stg cls prm thr last
        vecs[0]  = '{ 0, 100, 0, 0, 0, 0, 0};
        vecs[1]  = '{ 1, 101, 0, 0, 1, 0, 0};
        vecs[2]  = '{ 2, 102, 0, 0, 2, 0, 0};
        vecs[3]  = '{ 3, 103, 0, 1, 0, 0, 0};
        vecs[4]  = '{ 4, 104, 0, 1, 1, 0, 0};
        vecs[5]  = '{ 5, 105, 0, 1, 2, 0, 0};
        vecs[6]  = '{ 6, 106, 0, 1, 0, 1, 1};
        vecs[7]  = '{ 7, 107, 1, 0, 0, 0, 0};
        vecs[8]  = '{ 8, 108, 1, 0, 1, 0, 0};
        vecs[9]  = '{ 9, 109, 1, 0, 2, 0, 0};
        vecs[10] = '{10, 110, 1, 1, 0, 0, 0};
        vecs[11] = '{11, 111, 1, 1, 1, 0, 0};
        vecs[12] = '{12, 112, 1, 1, 2, 0, 0};
        vecs[13] = '{13, 113, 1, 1, 0, 1, 1};

        reset_fpga           = 1'b0;
        i_start              = 1'b0;
        i_param_ready        = 1'b0;
        i_stage_result_valid = 1'b0;
        i_stage_pass         = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        reset_fpga = 1'b1;
        tick();
        chk("idle_busy", int'(o_busy), 0);

        // Nominal: both stages pass
        run_window(1, 1, -1, 0, 0, -1, ba, bw, bd);
        compare_run(ba, bw, bd, 14, 1);

        // Backpressure on address 4
        run_window(1, 1, 4, 5, 0, -1, ba, bw, bd);
        compare_run(ba, bw, bd, 14, 1);

        // Stage 0 fails, stage 1 passes
        run_window(0, 1, -1, 0, 0, -1, ba, bw, bd);
        compare_run(ba, bw, bd, EARLY ? 7 : 14, 0);

        // Reset during EMIT of address 9, then a clean window
        run_window(1, 1, -1, 0, 0, 9, ba, bw, bd);
        chk("abort_no_done", done_cnt - bd, 0);
        tick();
        chk_all_zero("in_reset");
        reset_fpga = 1'b1;
        tick();
        run_window(1, 1, -1, 0, 0, -1, ba, bw, bd);
        compare_run(ba, bw, bd, 14, 1);

        // Spurious start and verdict strobes while emitting
        run_window(1, 1, -1, 0, 1, -1, ba, bw, bd);
        compare_run(ba, bw, bd, 14, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
